// File: rtl/uart_full_duplex_cfg.sv
`timescale 1ns/1ps
// Configurable full-duplex UART (DATA_BITS, optional even/odd parity, 1-2 stop bits) with synchronized, glitch-filtered receiver.
// tx_send is level-sampled only while idle and never queued; rx_flag and the error flags stay set until rx_flag_clr.
module uart_full_duplex_cfg #(
  parameter int baud_rate  = 5210,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_send,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_finish,
  input  logic                 rx,
  input  logic                 rx_flag_clr,
  output logic                 rx_flag,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int CW = $clog2(baud_rate);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(baud_rate - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(baud_rate / 2 - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);
  localparam logic          PAR_INIT  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e               tx_state_q;
  logic [CW-1:0]        tx_cnt_q;
  logic [IW-1:0]        tx_idx_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 tx_par_q, tx_q, tx_busy_q, tx_finish_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_sh_q     <= '0;
      tx_par_q    <= 1'b0;
      tx_q        <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_finish_q <= 1'b0;
    end else begin
      tx_finish_q <= 1'b0;
      if (tx_state_q == S_IDLE) begin
        if (tx_send) begin
          tx_sh_q    <= tx_data;
          tx_par_q   <= (^tx_data) ^ PAR_INIT;
          tx_q       <= 1'b0;
          tx_busy_q  <= 1'b1;
          tx_cnt_q   <= '0;
          tx_state_q <= S_START;
        end
      end else if (tx_cnt_q != BIT_LAST) begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end else begin
        tx_cnt_q <= '0;
        case (tx_state_q)
          S_START: begin
            tx_q       <= tx_sh_q[0];
            tx_sh_q    <= tx_sh_q >> 1;
            tx_idx_q   <= '0;
            tx_state_q <= S_DATA;
          end
          S_DATA: begin
            if (tx_idx_q != DATA_LAST) begin
              tx_q     <= tx_sh_q[0];
              tx_sh_q  <= tx_sh_q >> 1;
              tx_idx_q <= tx_idx_q + 1'b1;
            end else if (HAS_PAR) begin
              tx_q       <= tx_par_q;
              tx_state_q <= S_PARITY;
            end else begin
              tx_q       <= 1'b1;
              tx_idx_q   <= '0;
              tx_state_q <= S_STOP;
            end
          end
          S_PARITY: begin
            tx_q       <= 1'b1;
            tx_idx_q   <= '0;
            tx_state_q <= S_STOP;
          end
          S_STOP: begin
            // Finishing here lets a tx_send seen in the tx_finish cycle start the next frame at once.
            if (tx_idx_q != STOP_LAST) begin
              tx_idx_q <= tx_idx_q + 1'b1;
            end else begin
              tx_busy_q   <= 1'b0;
              tx_finish_q <= 1'b1;
              tx_state_q  <= S_IDLE;
            end
          end
          default: tx_state_q <= S_IDLE;
        endcase
      end
    end
  end

  logic rx_s1_q, rx_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  state_e               rx_state_q;
  logic [CW-1:0]        rx_cnt_q;
  logic [IW-1:0]        rx_idx_q;
  logic [DATA_BITS-1:0] rx_sh_q, rx_data_q;
  logic                 rx_perr_pend_q, rx_flag_q, rx_perr_q, rx_ferr_q, rx_ovr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q     <= S_IDLE;
      rx_cnt_q       <= '0;
      rx_idx_q       <= '0;
      rx_sh_q        <= '0;
      rx_data_q      <= '0;
      rx_perr_pend_q <= 1'b0;
      rx_flag_q      <= 1'b0;
      rx_perr_q      <= 1'b0;
      rx_ferr_q      <= 1'b0;
      rx_ovr_q       <= 1'b0;
    end else begin
      if (rx_flag_clr) begin
        rx_flag_q <= 1'b0;
        rx_perr_q <= 1'b0;
        rx_ferr_q <= 1'b0;
        rx_ovr_q  <= 1'b0;
      end
      case (rx_state_q)
        S_IDLE: begin
          if (!rx_s2_q) begin
            rx_cnt_q   <= '0;
            rx_state_q <= S_START;
          end
        end
        S_START: begin
          // Line back high at mid-start means a glitch, not a frame.
          if (rx_cnt_q != HALF_LAST) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end else begin
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (rx_cnt_q != BIT_LAST) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end else begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
            if (rx_idx_q != DATA_LAST) rx_idx_q <= rx_idx_q + 1'b1;
            else rx_state_q <= HAS_PAR ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (rx_cnt_q != BIT_LAST) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end else begin
            rx_cnt_q       <= '0;
            rx_perr_pend_q <= (^rx_sh_q) ^ rx_s2_q ^ PAR_INIT;
            rx_state_q     <= S_STOP;
          end
        end
        S_STOP: begin
          // Completion overrides a simultaneous rx_flag_clr.
          if (rx_cnt_q != BIT_LAST) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end else begin
            rx_cnt_q   <= '0;
            rx_data_q  <= rx_sh_q;
            rx_flag_q  <= 1'b1;
            rx_perr_q  <= HAS_PAR & rx_perr_pend_q;
            rx_ferr_q  <= ~rx_s2_q;
            rx_ovr_q   <= (rx_ovr_q | rx_flag_q) & ~rx_flag_clr;
            rx_state_q <= S_IDLE;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  assign tx            = tx_q;
  assign tx_busy       = tx_busy_q;
  assign tx_finish     = tx_finish_q;
  assign rx_flag       = rx_flag_q;
  assign rx_data       = rx_data_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;
endmodule

// File: tb/tb_uart_full_duplex_cfg.sv
`timescale 1ns/1ps
// Directed bench: an 8N1 instance and a 7E2 instance, both at 16 clocks per bit.
module tb_uart_full_duplex_cfg;
  logic clk, rst_n;
  int tests_run, fails;

  logic [7:0] tx_data1, rdata1;
  logic tx_send1, tx1, busy1, fin1, rx1, clr1, flag1, perr1, ferr1, ovr1, loop1, rx1_drv;
  logic [6:0] tx_data2, rdata2;
  logic tx_send2, tx2, busy2, fin2, rx2, clr2, flag2, perr2, ferr2, ovr2, loop2, rx2_drv;

  assign rx1 = loop1 ? tx1 : rx1_drv;
  assign rx2 = loop2 ? tx2 : rx2_drv;

  uart_full_duplex_cfg #(.baud_rate(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data1), .tx_send(tx_send1), .tx(tx1), .tx_busy(busy1),
    .tx_finish(fin1), .rx(rx1), .rx_flag_clr(clr1), .rx_flag(flag1), .rx_data(rdata1),
    .rx_parity_err(perr1), .rx_frame_err(ferr1), .rx_overrun(ovr1));

  uart_full_duplex_cfg #(.baud_rate(16), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_send(tx_send2), .tx(tx2), .tx_busy(busy2),
    .tx_finish(fin2), .rx(rx2), .rx_flag_clr(clr2), .rx_flag(flag2), .rx_data(rdata2),
    .rx_parity_err(perr2), .rx_frame_err(ferr2), .rx_overrun(ovr2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Serial driver: bits[0] goes first, each bit held 16 clocks, line left high afterwards.
  task automatic drive_bits(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 1) rx1_drv = bits[i]; else rx2_drv = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
    if (which == 1) rx1_drv = 1'b1; else rx2_drv = 1'b1;
  endtask

  task automatic pulse_clr(input int which);
    @(posedge clk); #1;
    if (which == 1) clr1 = 1'b1; else clr2 = 1'b1;
    @(posedge clk); #1;
    clr1 = 1'b0; clr2 = 1'b0;
  endtask

  task automatic test_reset();
    #23;
    tests_run++; if ({tx1, busy1, fin1} !== 3'b100) begin fails++; $display("FAIL reset_tx1 got tx/busy/fin=%b exp 100", {tx1, busy1, fin1}); end
    tests_run++; if ({flag1, perr1, ferr1, ovr1} !== 4'b0000) begin fails++; $display("FAIL reset_rx1_flags got %b exp 0000", {flag1, perr1, ferr1, ovr1}); end
    tests_run++; if (rdata1 !== 8'h00) begin fails++; $display("FAIL reset_rdata1 got %h exp 00", rdata1); end
    tests_run++; if ({tx2, busy2, flag2, rdata2} !== {3'b100, 7'h00}) begin fails++; $display("FAIL reset_dut2 got %b exp 1000000000", {tx2, busy2, flag2, rdata2}); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_tx_8n1();
    logic [9:0] seq;
    int fin_at, flag_at, nfin;
    bit found;
    seq = {1'b1, 8'hA5, 1'b0};
    fin_at = -1; flag_at = -1; nfin = 0; found = 0;
    loop1 = 1'b1;
    @(posedge clk); #1 tx_data1 = 8'hA5; tx_send1 = 1'b1;
    @(posedge clk); #1 tx_send1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (tx1 === 1'b0) begin found = 1; break; end
    end
    tests_run++; if (!found) begin fails++; $display("FAIL a5_start_fall tx stayed %b exp 0 within 4 cycles", tx1); end
    for (int c = 0; c < 200; c++) begin
      if (c % 16 == 8 && c < 160) begin
        tests_run++; if (tx1 !== seq[c/16]) begin fails++; $display("FAIL a5_bit%0d got %b exp %b", c/16, tx1, seq[c/16]); end
      end
      if (c == 100) begin
        tests_run++; if (busy1 !== 1'b1) begin fails++; $display("FAIL a5_busy_mid got %b exp 1", busy1); end
      end
      if (fin1 === 1'b1) begin nfin++; if (fin_at < 0) fin_at = c; end
      if (flag1 === 1'b1 && flag_at < 0) flag_at = c;
      @(negedge clk);
    end
    tests_run++; if (fin_at != 160 || nfin != 1) begin fails++; $display("FAIL a5_finish at %0d count %0d exp at 160 count 1", fin_at, nfin); end
    tests_run++; if (flag_at < 153 || flag_at > 155) begin fails++; $display("FAIL a5_rx_latency got %0d exp 153..155", flag_at); end
    tests_run++; if (rdata1 !== 8'hA5) begin fails++; $display("FAIL a5_loop_data got %h exp a5", rdata1); end
    tests_run++; if ({flag1, perr1, ferr1, ovr1, busy1} !== 5'b10000) begin fails++; $display("FAIL a5_loop_flags got %b exp 10000", {flag1, perr1, ferr1, ovr1, busy1}); end
  endtask

  task automatic test_7e2();
    logic [10:0] seq;
    int fin_at, nfin;
    bit found;
    seq = {2'b11, 1'b0, 7'h41, 1'b0};
    fin_at = -1; nfin = 0; found = 0;
    loop2 = 1'b1;
    @(posedge clk); #1 tx_data2 = 7'h41; tx_send2 = 1'b1;
    @(posedge clk); #1 tx_send2 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (tx2 === 1'b0) begin found = 1; break; end
    end
    tests_run++; if (!found) begin fails++; $display("FAIL 7e2_start_fall tx stayed %b exp 0", tx2); end
    for (int c = 0; c < 200; c++) begin
      if (c % 16 == 8 && c < 176) begin
        tests_run++; if (tx2 !== seq[c/16]) begin fails++; $display("FAIL 7e2_bit%0d got %b exp %b", c/16, tx2, seq[c/16]); end
      end
      if (fin2 === 1'b1) begin nfin++; if (fin_at < 0) fin_at = c; end
      @(negedge clk);
    end
    tests_run++; if (fin_at != 176 || nfin != 1) begin fails++; $display("FAIL 7e2_finish at %0d count %0d exp at 176 count 1", fin_at, nfin); end
    tests_run++; if ({rdata2, flag2, perr2, ferr2} !== {7'h41, 3'b100}) begin fails++; $display("FAIL 7e2_loop got data %h flag/perr/ferr %b exp 41 100", rdata2, {flag2, perr2, ferr2}); end
    loop2 = 1'b0;
    pulse_clr(2);
    drive_bits(2, {5'b0, 2'b11, 1'b1, 7'h41, 1'b0}, 11);
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests_run++; if ({flag2, perr2, ferr2, ovr2} !== 4'b1100) begin fails++; $display("FAIL 7e2_parity_err got flag/perr/ferr/ovr %b exp 1100", {flag2, perr2, ferr2, ovr2}); end
    tests_run++; if (rdata2 !== 7'h41) begin fails++; $display("FAIL 7e2_parity_data got %h exp 41", rdata2); end
  endtask

  task automatic test_frame_err();
    loop1 = 1'b0;
    pulse_clr(1);
    drive_bits(1, {6'b0, 1'b0, 8'h5A, 1'b0}, 10);
    repeat (30) @(posedge clk);
    @(negedge clk);
    tests_run++; if ({flag1, ferr1, perr1, ovr1} !== 4'b1100) begin fails++; $display("FAIL frame_err_flags got flag/ferr/perr/ovr %b exp 1100", {flag1, ferr1, perr1, ovr1}); end
    tests_run++; if (rdata1 !== 8'h5A) begin fails++; $display("FAIL frame_err_data got %h exp 5a", rdata1); end
    pulse_clr(1);
    @(negedge clk);
    tests_run++; if ({flag1, ferr1} !== 2'b00) begin fails++; $display("FAIL frame_err_clear got flag/ferr %b exp 00", {flag1, ferr1}); end
  endtask

  task automatic test_overrun();
    drive_bits(1, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
    drive_bits(1, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
    repeat (8) @(posedge clk);
    @(negedge clk);
    tests_run++; if ({flag1, ovr1, rdata1} !== {2'b11, 8'h22}) begin fails++; $display("FAIL overrun got flag/ovr %b data %h exp 11 22", {flag1, ovr1}, rdata1); end
    @(posedge clk); #1;
    fork
      drive_bits(1, {6'b0, 1'b1, 8'h33, 1'b0}, 10);
      begin
        repeat (154) @(posedge clk);
        #1 clr1 = 1'b1;
        @(posedge clk);
        #1 clr1 = 1'b0;
      end
    join
    @(negedge clk);
    tests_run++; if ({flag1, ovr1, ferr1} !== 3'b100) begin fails++; $display("FAIL clr_vs_completion got flag/ovr/ferr %b exp 100", {flag1, ovr1, ferr1}); end
    tests_run++; if (rdata1 !== 8'h33) begin fails++; $display("FAIL clr_vs_completion_data got %h exp 33", rdata1); end
  endtask

  task automatic test_glitch();
    pulse_clr(1);
    rx1_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx1_drv = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    tests_run++; if (flag1 !== 1'b0) begin fails++; $display("FAIL glitch_reject got flag %b exp 0", flag1); end
  endtask

  task automatic test_back_to_back();
    int nfin;
    bit dropped;
    nfin = 0; dropped = 0;
    loop1 = 1'b1;
    pulse_clr(1);
    tx_data1 = 8'h96; tx_send1 = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (fin1 === 1'b1) begin
        nfin++;
        if (!dropped) begin
          dropped = 1;
          @(posedge clk); #1 tx_send1 = 1'b0;
          @(negedge clk);
          tests_run++; if ({tx1, busy1} !== 2'b01) begin fails++; $display("FAIL b2b_second_start got tx/busy %b exp 01", {tx1, busy1}); end
        end
      end
    end
    tx_send1 = 1'b0;
    tests_run++; if (nfin != 2) begin fails++; $display("FAIL b2b_finish_count got %0d exp 2", nfin); end
    tests_run++; if ({rdata1, flag1, ovr1} !== {8'h96, 2'b11}) begin fails++; $display("FAIL b2b_loop got data %h flag/ovr %b exp 96 11", rdata1, {flag1, ovr1}); end
  endtask

  task automatic test_reset_midframe();
    bit got;
    got = 0;
    pulse_clr(1);
    tx_data1 = 8'h3C; tx_send1 = 1'b1;
    @(posedge clk); #1 tx_send1 = 1'b0;
    repeat (21) @(posedge clk);
    @(negedge clk);
    tests_run++; if ({tx1, busy1} !== 2'b01) begin fails++; $display("FAIL rst_pre got tx/busy %b exp 01", {tx1, busy1}); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if ({tx1, busy1} !== 2'b10) begin fails++; $display("FAIL rst_async got tx/busy %b exp 10", {tx1, busy1}); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    tests_run++; if ({flag1, rdata1} !== 9'h000) begin fails++; $display("FAIL rst_discard got flag %b data %h exp 0 00", flag1, rdata1); end
    @(posedge clk); #1 tx_send1 = 1'b1;
    @(posedge clk); #1 tx_send1 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (fin1 === 1'b1) begin got = 1; break; end
    end
    tests_run++; if (!got) begin fails++; $display("FAIL rst_resend_finish no tx_finish within 200 cycles exp 1"); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++; if ({rdata1, flag1, perr1, ferr1, ovr1} !== {8'h3C, 4'b1000}) begin fails++; $display("FAIL rst_resend_rx got data %h flags %b exp 3c 1000", rdata1, {flag1, perr1, ferr1, ovr1}); end
  endtask

  initial begin
    tests_run = 0; fails = 0;
    rst_n = 1'b0;
    tx_data1 = '0; tx_send1 = 1'b0; clr1 = 1'b0; loop1 = 1'b0; rx1_drv = 1'b1;
    tx_data2 = '0; tx_send2 = 1'b0; clr2 = 1'b0; loop2 = 1'b0; rx2_drv = 1'b1;
    test_reset();
    test_tx_8n1();
    test_7e2();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
